sys_in_feeder: RTL and testbench

// - Activation feeder sitting directly upstream of the systolic array and its conv controller.
// - Accepts one ROW-wide activation vector per beat from the line buffer (valid/ready).
// - Skews lane r by r cycles so the data wavefront enters the array diagonally.
// - Streams a programmed number of vectors, drains the skew with zeros, then pulses done.

---
 rtl/sys_in_feeder.sv | 159 +++++++++++++++
 tb/tb_sys_in_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_in_feeder.sv
// Activation feeder for the systolic array: accepts ROW-lane vectors, skews lane r by r cycles,
// drains the skew with zeros and pulses done. Optional stall counter behind `FEEDER_PERF_EN.
module sys_in_feeder #(
    parameter int ROW   = 32,
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic [CNT_W-1:0]    vec_count,
    input  logic [ROW*DW-1:0]   in_vec,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ROW-1:0]      row_en,
    output logic [ROW*DW-1:0]   row_data,
    output logic [ROW-1:0]      row_valid,
    output logic                busy,
    output logic                done
`ifdef FEEDER_PERF_EN
    ,
    output logic [15:0]         stall_cycles
`endif
);

    localparam int DRN_W = (ROW > 1) ? $clog2(ROW) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               shift_en;
    logic               beat;

    // Handshake: a vector moves when in_valid && in_ready on a rising edge; in_ready is high
    // for the whole STREAM state and depends only on state, never on in_valid.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        drain_d  = drain_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (vec_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = STREAM;
                        rem_d   = vec_count;
                    end
                end
            end
            STREAM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                        drain_d = DRN_W'(ROW - 1);
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
        end
    end

    assign shift_en = (state_q == STREAM) || (state_q == DRAIN);
    assign beat     = (state_q == STREAM) && in_valid;

    // Lane r is an (r+1)-deep shift line; the final stage is masked by row_en after the register.
    for (genvar r = 0; r < ROW; r++) begin : g_lane
        logic [r:0][DW-1:0] dat_q, dat_d;
        logic [r:0]         vld_q, vld_d;

        always_comb begin
            dat_d = dat_q;
            vld_d = vld_q;
            if (shift_en) begin
                dat_d[0] = beat ? in_vec[r*DW +: DW] : '0;
                vld_d[0] = beat;
                for (int k = 1; k <= r; k++) begin
                    dat_d[k] = dat_q[k-1];
                    vld_d[k] = vld_q[k-1];
                end
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                dat_q <= '0;
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end

        assign row_data[r*DW +: DW] = row_en[r] ? dat_q[r] : '0;
        assign row_valid[r]         = vld_q[r] & row_en[r];
    end

`ifdef FEEDER_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Counts STREAM cycles starved by the line buffer; restarts with each accepted start.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == STREAM) && !in_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sys_in_feeder.sv
// Bench for sys_in_feeder (ROW=4): per-row expected queues filled by a cycle-level model of the
// feeder's accept/skew/drain rules, drained by a negedge monitor. Honours `FEEDER_PERF_EN.
module tb_sys_in_feeder;

    localparam int ROW   = 4;
    localparam int DW    = 16;
    localparam int CNT_W = 16;

    logic                clk = 1'b0;
    logic                nrst = 1'b0;
    logic                start = 1'b0;
    logic [CNT_W-1:0]    vec_count = '0;
    logic [ROW*DW-1:0]   in_vec = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [ROW-1:0]      row_en = '1;
    logic [ROW*DW-1:0]   row_data;
    logic [ROW-1:0]      row_valid;
    logic                busy;
    logic                done;
`ifdef FEEDER_PERF_EN
    logic [15:0]         stall_cycles;
`endif

    sys_in_feeder #(.ROW(ROW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .nrst(nrst), .start(start), .vec_count(vec_count),
        .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
        .row_en(row_en), .row_data(row_data), .row_valid(row_valid),
        .busy(busy), .done(done)
`ifdef FEEDER_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    // ---------------- clock / cycle index ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q [ROW][$];
    int            due_q [ROW][$];
    int            done_q[$];
    int            rem = 0;
    int            drain_end = -100;
    int            stall_m = 0;
    bit            exp_ready = 1'b0;
    bit            exp_busy = 1'b0;
    int            last_done = -1;
    int            acc_cnt = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bit            exp_done;
        logic [DW-1:0] ed;
        bit            ev;
        check("in_ready", in_ready, exp_ready);
        check("busy", busy, exp_busy);
        exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
        if (exp_done) void'(done_q.pop_front());
        check("done", done, exp_done);
        if (done) last_done = cyc;
        if (in_ready && in_valid) acc_cnt++;
        for (int r = 0; r < ROW; r++) begin
            ed = '0;
            ev = 1'b0;
            if ((due_q[r].size() > 0) && (due_q[r][0] == cyc)) begin
                void'(due_q[r].pop_front());
                if (row_en[r]) begin
                    ed = exp_q[r][0];
                    ev = 1'b1;
                end
                void'(exp_q[r].pop_front());
            end
            check($sformatf("row_data[%0d]", r), row_data[r*DW +: DW], ed);
            check($sformatf("row_valid[%0d]", r), row_valid[r], ev);
        end
    end

    // ---------------- driver + reference model ----------------
    // One clock of stimulus. The model: after an accepted start the feeder takes one vector per
    // cycle with in_valid until the count is used up; element of lane r taken in cycle n shows on
    // row r in cycle n+1+r; busy lasts ROW cycles past the last beat and done follows.
    task automatic tick(input bit v, input logic [ROW*DW-1:0] vec, input bit st, input int cnt);
        bit idle;
        bit done_now;
        @(posedge clk);
        #1;
        exp_ready = (rem > 0);
        exp_busy  = (rem > 0) || (cyc <= drain_end);
        done_now  = (done_q.size() > 0) && (done_q[0] == cyc);
        idle      = !exp_busy && !done_now;
        in_valid  = v;
        in_vec    = vec;
        start     = st;
        vec_count = CNT_W'(cnt);
        if (rem > 0) begin
            if (v) begin
                for (int r = 0; r < ROW; r++) begin
                    exp_q[r].push_back(vec[r*DW +: DW]);
                    due_q[r].push_back(cyc + 1 + r);
                end
                rem--;
                if (rem == 0) begin
                    drain_end = cyc + ROW;
                    done_q.push_back(cyc + 1 + ROW);
                end
            end else if (stall_m < 65535) begin
                stall_m++;
            end
        end
        if (st && idle && nrst) begin
            stall_m = 0;
            if (cnt == 0) done_q.push_back(cyc + 1);
            else rem = cnt;
        end
    endtask

    task automatic reset_mid();
        #2;
        nrst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_row_data", row_data, 0);
        check("rst_row_valid", row_valid, 0);
        rem = 0;
        drain_end = -100;
        done_q.delete();
        for (int r = 0; r < ROW; r++) begin
            exp_q[r].delete();
            due_q[r].delete();
        end
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
        tick(1'b0, '0, 1'b0, 0);
        tick(1'b0, '0, 1'b0, 0);
        nrst = 1'b1;
    endtask

    // mode: 0 random, 1 directed data, 2 directed + 2 bubbles, 3 restart mid-stream, 4 reset in drain
    task automatic run(input int n, input int pct, input logic [ROW-1:0] en, input int mode,
                       output int s_cyc);
        int                k;
        int                guard;
        int                b;
        bit                v;
        bit                st;
        logic [ROW*DW-1:0] vec;
        k = 0;
        guard = 0;
        row_en = en;
        tick(1'b0, '0, 1'b1, n);
        s_cyc = cyc;
        while ((rem > 0 || cyc <= drain_end || done_q.size() > 0) && guard < 1000) begin
            v = (mode == 0) ? ($urandom_range(99) < pct) : 1'b1;
            if (mode == 2 && (k == 1 || k == 2)) v = 1'b0;
            b = n - rem;
            for (int r = 0; r < ROW; r++) begin
                if (mode == 0) vec[r*DW +: DW] = DW'($urandom_range(65535, 1));
                else vec[r*DW +: DW] = DW'(4 * b + r + 1);
            end
            st = (mode == 3 && k == 1);
            tick(v, vec, st, 9);
            k++;
            guard++;
            if (mode == 4 && rem == 0 && drain_end - cyc == 1) reset_mid();
        end
        check("run_bound", guard >= 1000, 0);
        tick(1'b0, '0, 1'b0, 0);
`ifdef FEEDER_PERF_EN
        if (mode != 4) check("stall_cycles", stall_cycles, stall_m);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s;
        int acc0;
        int done0;
        repeat (3) tick(1'b0, '0, 1'b0, 0);
        check("reset_row_data", row_data, 0);
        check("reset_row_valid", row_valid, 0);
        check("reset_busy", busy, 0);
        nrst = 1'b1;
        tick(1'b0, '0, 1'b0, 0);

        // basic stream: start sampled at the end of cycle s, done 7 cycles after that edge
        run(3, 100, 4'b1111, 1, s);
        check("done_latency", last_done - s, 8);

        // two stall cycles after the first beat push done out by two
        run(3, 100, 4'b1111, 2, s);
        check("done_latency_bubbles", last_done - s, 10);
`ifdef FEEDER_PERF_EN
        check("stall_two", stall_cycles, 2);
`endif

        // zero-length job
        run(0, 100, 4'b1111, 1, s);
        check("done_latency_zero", last_done - s, 1);

        // masked row
        run(3, 100, 4'b1011, 1, s);
        check("done_latency_masked", last_done - s, 8);

        // start while streaming is ignored
        acc0 = acc_cnt;
        run(3, 100, 4'b1111, 3, s);
        check("restart_ignored_beats", acc_cnt - acc0, 3);

        // reset during drain: no done, then a fresh job runs normally
        done0 = last_done;
        run(3, 100, 4'b1111, 4, s);
        check("no_done_after_reset", last_done, done0);
        run(3, 100, 4'b1111, 1, s);
        check("done_latency_after_reset", last_done - s, 8);

        for (int i = 0; i < 20; i++) begin
            run($urandom_range(12, 1), $urandom_range(100, 30), ROW'($urandom_range(15)), 0, s);
        end

        repeat (3) tick(1'b0, '0, 1'b0, 0);
        check("leftover_expect", due_q[0].size() + due_q[1].size() + due_q[2].size()
              + due_q[3].size() + done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
